// File: rtl/dbc_port_event_sched_pkg.sv
// Shared definitions for the DbC port event scheduler: run-state and event-code
// encodings, change-bit indices and the event priority picker.
package dbc_port_event_sched_pkg;

    typedef enum logic [2:0] {
        DBC_OFF  = 3'd0,
        DBC_DISC = 3'd1,
        DBC_ENA  = 3'd2,
        DBC_RST  = 3'd3,
        DBC_CFG  = 3'd4,
        DBC_ERR  = 3'd5
    } dbc_state_e;

    typedef enum logic [1:0] {
        EVT_CSC = 2'd0,
        EVT_PLC = 2'd1,
        EVT_PRC = 2'd2,
        EVT_CEC = 2'd3
    } evt_code_e;

    typedef enum logic {
        SCH_IDLE = 1'b0,
        SCH_PEND = 1'b1
    } sched_state_e;

    localparam int CHG_CSC = 0;
    localparam int CHG_PLC = 1;
    localparam int CHG_PRC = 2;
    localparam int CHG_CEC = 3;

    // Fixed priority CEC > PRC > CSC > PLC; PLC is the fallthrough.
    function automatic evt_code_e pick_code(input logic [3:0] pend);
        evt_code_e code;
        if (pend[CHG_CEC]) begin
            code = EVT_CEC;
        end else if (pend[CHG_PRC]) begin
            code = EVT_PRC;
        end else if (pend[CHG_CSC]) begin
            code = EVT_CSC;
        end else begin
            code = EVT_PLC;
        end
        return code;
    endfunction

endpackage

// File: rtl/dbc_port_event_sched_chg_latch.sv
// dbc_chg_latch: 4-bit sticky change register with write-1-to-clear and a
// reported mask that never holds a bit whose sticky bit is clear.
module dbc_chg_latch (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dce,
    input  logic [3:0] chg_set,
    input  logic [3:0] chg_clr,
    input  logic [3:0] rpt_set,
    output logic [3:0] chg_sts,
    output logic [3:0] reported
);

    logic [3:0] sts_r;
    logic [3:0] rpt_r;
    logic [3:0] sts_next_s;
    logic [3:0] rpt_next_s;

    // Next sticky/reported values; masking with sts lets a bit cleared mid-report be reported again.
    always_comb begin
        sts_next_s = 4'b0000;
        rpt_next_s = 4'b0000;
        if (dce) begin
            sts_next_s = (sts_r & ~chg_clr) | chg_set;
            rpt_next_s = ((rpt_r & ~chg_clr) | rpt_set) & sts_next_s;
        end else begin
            sts_next_s = 4'b0000;
            rpt_next_s = 4'b0000;
        end
    end

    // Sticky and reported registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sts_r <= 4'b0000;
            rpt_r <= 4'b0000;
        end else begin
            sts_r <= sts_next_s;
            rpt_r <= rpt_next_s;
        end
    end

    assign chg_sts  = sts_r;
    assign reported = rpt_r;

endmodule

// File: rtl/dbc_port_event_sched.sv
// DbC port run-state FSM plus Port Status Change event scheduler.
// Optional event handshake timeout is enabled by defining DBC_EVT_TIMEOUT_EN.
module dbc_port_event_sched
    import dbc_port_event_sched_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 1024,
    parameter int unsigned TMO_W      = 11
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dce,
    input  logic       ccs,
    input  logic       pr,
    input  logic       cfg_done,
    input  logic [3:0] chg_set,
    input  logic [3:0] chg_clr,
    output logic [3:0] chg_sts,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic [2:0] dbc_state,
    output logic       dcr,
    output logic       irq,
    output logic       tmo_err
);

    dbc_state_e   state_r, state_next_s;
    sched_state_e sched_r, sched_next_s;
    evt_code_e    code_r, code_next_s;
    logic         valid_r;
    logic         irq_r, irq_next_s;
    logic         dcr_r;
    logic [3:0]   rpt_set_s;
    logic [3:0]   reported_s;
    logic [3:0]   pend_s;

`ifdef DBC_EVT_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    logic [TMO_W-1:0] cnt_r, cnt_next_s;
    logic             tmo_r, tmo_next_s, tmo_hit_s;
`endif

    dbc_chg_latch u_chg_latch (
        .clock    (clock),
        .reset_n  (reset_n),
        .dce      (dce),
        .chg_set  (chg_set),
        .chg_clr  (chg_clr),
        .rpt_set  (rpt_set_s),
        .chg_sts  (chg_sts),
        .reported (reported_s)
    );

    assign pend_s = chg_sts & ~reported_s;

    // Run-state next-state logic, rules applied in priority order.
    always_comb begin
        state_next_s = state_r;
        if (!dce) begin
            state_next_s = DBC_OFF;
        end else if (state_r == DBC_OFF) begin
            state_next_s = DBC_DISC;
        end else if (!ccs) begin
            state_next_s = DBC_DISC;
        end else if (chg_set[CHG_CEC] &&
                     ((state_r == DBC_ENA) || (state_r == DBC_RST) || (state_r == DBC_CFG))) begin
            state_next_s = DBC_ERR;
        end else begin
            case (state_r)
                DBC_DISC: state_next_s = DBC_ENA;
                DBC_ENA: begin
                    if (pr) begin
                        state_next_s = DBC_RST;
                    end else if (cfg_done) begin
                        state_next_s = DBC_CFG;
                    end else begin
                        state_next_s = DBC_ENA;
                    end
                end
                DBC_RST: begin
                    if (!pr) begin
                        state_next_s = DBC_ENA;
                    end else begin
                        state_next_s = DBC_RST;
                    end
                end
                DBC_CFG: begin
                    if (pr) begin
                        state_next_s = DBC_RST;
                    end else begin
                        state_next_s = DBC_CFG;
                    end
                end
                DBC_ERR: state_next_s = DBC_ERR;
                default: state_next_s = DBC_OFF;
            endcase
        end
    end

    // Scheduler next-state logic: pick, hold, complete (or time out) one event at a time.
    always_comb begin
        sched_next_s = sched_r;
        code_next_s  = code_r;
        rpt_set_s    = 4'b0000;
        irq_next_s   = 1'b0;
`ifdef DBC_EVT_TIMEOUT_EN
        cnt_next_s   = cnt_r;
        tmo_hit_s    = 1'b0;
`endif
        case (sched_r)
            SCH_IDLE: begin
                if (dce && (pend_s != 4'b0000)) begin
                    sched_next_s = SCH_PEND;
                    code_next_s  = pick_code(pend_s);
`ifdef DBC_EVT_TIMEOUT_EN
                    cnt_next_s   = {TMO_W{1'b0}};
`endif
                end else begin
                    sched_next_s = SCH_IDLE;
                end
            end
            SCH_PEND: begin
                if (!dce) begin
                    sched_next_s = SCH_IDLE;
                end else if (evt_ready) begin
                    sched_next_s = SCH_IDLE;
                    rpt_set_s    = 4'b0001 << code_r;
                    irq_next_s   = 1'b1;
`ifdef DBC_EVT_TIMEOUT_EN
                end else if (cnt_r == TMO_LAST) begin
                    sched_next_s = SCH_IDLE;
                    rpt_set_s    = 4'b0001 << code_r;
                    tmo_hit_s    = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + TMO_W'(1);
                end
`else
                end else begin
                    sched_next_s = SCH_PEND;
                end
`endif
            end
            default: sched_next_s = SCH_IDLE;
        endcase
`ifdef DBC_EVT_TIMEOUT_EN
        tmo_next_s = dce & (tmo_r | tmo_hit_s);
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= DBC_OFF;
            sched_r <= SCH_IDLE;
            code_r  <= EVT_CSC;
            valid_r <= 1'b0;
            irq_r   <= 1'b0;
            dcr_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sched_r <= sched_next_s;
            code_r  <= code_next_s;
            valid_r <= (sched_next_s == SCH_PEND);
            irq_r   <= irq_next_s;
            dcr_r   <= (state_next_s == DBC_CFG);
        end
    end

`ifdef DBC_EVT_TIMEOUT_EN
    // Handshake timeout counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_r <= {TMO_W{1'b0}};
            tmo_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            tmo_r <= tmo_next_s;
        end
    end
    assign tmo_err = tmo_r;
`else
    assign tmo_err = 1'b0;
`endif

    assign dbc_state = state_r;
    assign evt_valid = valid_r;
    assign evt_code  = code_r;
    assign irq       = irq_r;
    assign dcr       = dcr_r;

endmodule
